// File: rtl/rr_weighted_arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter.
//   arb_state_e  : controller states (exposed on the top-level debug port)
//   *_DEF        : default parameter values
//   MAX_*        : upper bounds used to size the generic weight helper
//   weight_of()  : extracts one requester's weight field, 0 maps to 1
package rr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      GRANT = 2'd2
   } arb_state_e;

   localparam int N_DEF        = 4;
   localparam int WEIGHT_W_DEF = 4;
   localparam int REQ2GNT_DEF  = 2;

   localparam int MAX_N        = 8;
   localparam int MAX_WEIGHT_W = 8;

   // cfg is the weight bus zero-extended to the maximum size; ww is the
   // real field width. A zero weight still grants one cycle.
   function automatic logic [MAX_WEIGHT_W-1:0] weight_of(
      input logic [MAX_N*MAX_WEIGHT_W-1:0] cfg,
      input int                            i,
      input int                            ww = WEIGHT_W_DEF
   );
      logic [MAX_WEIGHT_W-1:0] f;
      f = '0;
      for (int b = 0; b < MAX_WEIGHT_W; b++) begin
         if (b < ww) f[b] = cfg[i*ww + b];
      end
      if (f == '0) f = {{(MAX_WEIGHT_W-1){1'b0}}, 1'b1};
      return f;
   endfunction

endpackage

// File: rtl/rr_weighted_arb_if.sv
// Requester-side bus of the weighted round-robin arbiter.
//   req        : request vector, one bit per requester
//   cfg_weight : per-requester maximum burst length, field i at [i*WEIGHT_W +: WEIGHT_W]
//   gnt        : one-hot grant
//   gnt_id     : index of the current or pending winner
//   gnt_valid  : |gnt
//   busy       : arbiter is not idle
// Handshake: a requester raises req[i] and holds it until it has finished;
// gnt[i] is only ever high in a cycle where req[i] is also high, so a
// transfer happens exactly in cycles with req[i] && gnt[i]. Dropping req[i]
// ends the burst (or cancels a pending grant) without further cycles.
interface rr_weighted_arb_if #(
   parameter int N        = 4,
   parameter int WEIGHT_W = 4
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]          req;
   logic [N*WEIGHT_W-1:0] cfg_weight;
   logic [N-1:0]          gnt;
   logic [IW-1:0]         gnt_id;
   logic                  gnt_valid;
   logic                  busy;

   modport master (
      output req, cfg_weight,
      input  gnt, gnt_id, gnt_valid, busy
   );

   modport slave (
      input  req, cfg_weight,
      output gnt, gnt_id, gnt_valid, busy
   );

endinterface

// File: rtl/rr_weighted_arb_pick.sv
// Rotating priority encoder: finds the first set request bit searching
// ptr, ptr+1, ... modulo N.
//   req : request vector
//   ptr : starting search position
//   any : at least one request is set
//   idx : index of the first set bit at or after ptr (wrapping)
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] idx
);

   int pos;

   // Walk the offsets from farthest to nearest so the nearest set bit is
   // the last one written and therefore wins.
   always_comb begin
      any = |req;
      idx = '0;
      pos = 0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         if (req[pos]) idx = IW'(pos);
      end
   end

endmodule

// File: rtl/rr_weighted_arb.sv
// Four-requester (parameterised) weighted round-robin arbiter.
// An IDLE cycle picks a winner round-robin from ptr, the grant starts exactly
// REQ2GNT cycles later, and the winner then holds the resource for up to its
// weight in cycles. Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : requester bus (req/cfg_weight in, gnt/gnt_id/gnt_valid/busy out)
//   dbg_state  : current controller state
//   dbg_ptr    : current round-robin search start
module rr_weighted_arb
   import rr_arb_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int WEIGHT_W = WEIGHT_W_DEF,
   parameter int REQ2GNT  = REQ2GNT_DEF,
   localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   rr_weighted_arb_if.slave        bus,
   output arb_state_e              dbg_state,
   output logic [IW-1:0]           dbg_ptr
);

   localparam int WCW = (REQ2GNT > 1) ? $clog2(REQ2GNT) : 1;
   localparam int CW  = MAX_WEIGHT_W;

   arb_state_e           state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [IW-1:0]        win_q, win_d;
   logic [WCW-1:0]       wait_q, wait_d;
   logic [CW-1:0]        credit_q, credit_d;

   logic                 pick_any;
   logic [IW-1:0]        pick_idx;
   logic [IW-1:0]        wsel_idx;
   logic [MAX_N*MAX_WEIGHT_W-1:0] cfg_ext;
   logic [CW-1:0]        load_credit;
   logic [N-1:0]         gnt_c;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req (bus.req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   // The credit is loaded on the transition into GRANT. With REQ2GNT==1 that
   // transition leaves IDLE, so the freshly picked index selects the weight.
   always_comb begin
      cfg_ext = '0;
      cfg_ext[N*WEIGHT_W-1:0] = bus.cfg_weight;
      wsel_idx    = (state_q == IDLE) ? pick_idx : win_q;
      load_credit = weight_of(cfg_ext, int'(wsel_idx), WEIGHT_W);
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      win_d    = win_q;
      wait_d   = wait_q;
      credit_d = credit_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               win_d = pick_idx;
               if (REQ2GNT == 1) begin
                  state_d  = GRANT;
                  credit_d = load_credit;
               end else begin
                  state_d = WAIT;
                  wait_d  = WCW'(REQ2GNT - 1);
               end
            end
         end
         WAIT: begin
            // A winner that withdraws before its grant forfeits its turn
            // without moving the pointer.
            if (!bus.req[win_q]) begin
               state_d = IDLE;
            end else if (wait_q == WCW'(1)) begin
               state_d  = GRANT;
               credit_d = load_credit;
            end else begin
               wait_d = wait_q - WCW'(1);
            end
         end
         GRANT: begin
            if (!bus.req[win_q] || credit_q == CW'(1)) begin
               state_d = IDLE;
               ptr_d   = (win_q == IW'(N - 1)) ? '0 : win_q + IW'(1);
            end else begin
               credit_d = credit_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         win_q    <= '0;
         wait_q   <= '0;
         credit_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         wait_q   <= wait_d;
         credit_q <= credit_d;
      end
   end

   // Grant is qualified by the live request so it never outlives req.
   always_comb begin
      gnt_c = '0;
      if (state_q == GRANT && bus.req[win_q]) gnt_c[win_q] = 1'b1;
   end

   assign bus.gnt       = gnt_c;
   assign bus.gnt_valid = |gnt_c;
   assign bus.gnt_id    = win_q;
   assign bus.busy      = (state_q != IDLE);
   assign dbg_state     = state_q;
   assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_rr_weighted_arb.sv
// Bench for rr_weighted_arb: directed scenarios with hand-derived expected
// waveforms, then randomized traffic against a cycle-timeline reference model.
module tb_rr_weighted_arb;
   import rr_arb_pkg::*;

   localparam int N  = 4;
   localparam int WW = 4;
   localparam int R  = 2;
   localparam int IW = 2;
   localparam int OW = 1 + IW + N;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rr_weighted_arb_if #(.N(N), .WEIGHT_W(WW)) bus ();
   arb_state_e    dbg_state;
   logic [IW-1:0] dbg_ptr;

   rr_weighted_arb #(.N(N), .WEIGHT_W(WW), .REQ2GNT(R)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state),
      .dbg_ptr   (dbg_ptr)
   );

   int checks = 0;
   int errors = 0;
   logic [OW-1:0] exp_q[$];

   // ---------------- reference model ----------------
   // An arbitration episode is described by its winner, the cycle number of
   // its first grant cycle and the credits left; cyc numbers clock periods.
   int m_active = 0;
   int m_w      = 0;
   int m_start  = 0;
   int m_left   = 0;
   int m_ptr    = 0;
   int m_id     = 0;
   int cyc      = 0;

   function automatic int wt(input logic [N*WW-1:0] c, input int i);
      int f;
      f = int'((c >> (i * WW)) & 16'h000F);
      return (f == 0) ? 1 : f;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_active = 0; m_ptr = 0; m_id = 0; m_w = 0; m_left = 0;
      end else if (m_active == 0) begin
         if (bus.req != '0) begin
            for (int k = N - 1; k >= 0; k--)
               if (bus.req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
            m_active = 1;
            m_id     = m_w;
            m_start  = cyc + R;
            if (R == 1) m_left = wt(bus.cfg_weight, m_w);
         end
      end else if (cyc < m_start) begin
         if (!bus.req[m_w]) m_active = 0;
         else if (cyc == m_start - 1) m_left = wt(bus.cfg_weight, m_w);
      end else begin
         if (!bus.req[m_w] || m_left == 1) begin
            m_active = 0;
            m_ptr    = (m_w + 1) % N;
         end else begin
            m_left = m_left - 1;
         end
      end
      cyc = cyc + 1;
   end

   function automatic logic [OW-1:0] model_out(input logic [N-1:0] r);
      logic [N-1:0] g;
      g = '0;
      if (m_active != 0 && cyc >= m_start && r[m_w]) g[m_w] = 1'b1;
      return {(m_active != 0), IW'(m_id), g};
   endfunction

   // ---------------- driver tasks ----------------
   // Leaves the bench at a falling edge with reset released and the DUT idle.
   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b1;
      bus.req = '0;
      @(negedge clk);
      reset   = 1'b0;
   endtask

   task automatic settle();
      bus.req = '0;
      repeat (4) @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bus.cfg_weight = '0;
      do_reset();
      #1;
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b expected 0000", bus.gnt); end
      checks++; if (bus.gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id got %0d expected 0", bus.gnt_id); end
      checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gnt_valid got %b expected 0", bus.gnt_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d expected IDLE", dbg_state); end
      checks++; if (dbg_ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr got %0d expected 0", dbg_ptr); end
   endtask

   task automatic test_single_request();
      logic [8:0] exp_g;
      logic [8:0] exp_b;
      exp_g = 9'b110011100;   // bit n: gnt[0] expected in cycle n after req rises
      exp_b = 9'b111011110;
      bus.cfg_weight = 16'h0003;
      do_reset();
      for (int rel = 0; rel < 9; rel++) begin
         if (rel != 0) @(negedge clk);
         bus.req = 4'b0001;
         #1;
         checks++; if (bus.gnt !== {3'b000, exp_g[rel]}) begin errors++; $display("FAIL single_gnt c%0d got %b expected %b", rel, bus.gnt, {3'b000, exp_g[rel]}); end
         checks++; if (bus.busy !== exp_b[rel]) begin errors++; $display("FAIL single_busy c%0d got %b expected %b", rel, bus.busy, exp_b[rel]); end
         checks++; if (bus.gnt_id !== 2'd0) begin errors++; $display("FAIL single_id c%0d got %0d expected 0", rel, bus.gnt_id); end
      end
      settle();
   endtask

   task automatic test_rotation();
      logic [N-1:0] e;
      bus.cfg_weight = 16'h1111;
      do_reset();
      for (int rel = 0; rel < 15; rel++) begin
         if (rel != 0) @(negedge clk);
         bus.req = 4'b1111;
         #1;
         e = '0;
         if (rel >= 2 && (rel - 2) % 3 == 0) e[((rel - 2) / 3) % 4] = 1'b1;
         checks++; if (bus.gnt !== e) begin errors++; $display("FAIL rotation_gnt c%0d got %b expected %b", rel, bus.gnt, e); end
         checks++; if (bus.gnt_valid !== (e != 0)) begin errors++; $display("FAIL rotation_valid c%0d got %b expected %b", rel, bus.gnt_valid, (e != 0)); end
      end
      settle();
   endtask

   task automatic test_early_release();
      int n_gnt;
      n_gnt = 0;
      bus.cfg_weight = 16'h0800;
      do_reset();
      for (int rel = 0; rel < 6; rel++) begin
         if (rel != 0) @(negedge clk);
         bus.req = (rel < 5) ? 4'b0100 : 4'b0000;
         #1;
         if (bus.gnt[2]) n_gnt++;
         checks++; if ((bus.gnt & ~bus.req) !== 4'b0000) begin errors++; $display("FAIL early_gnt_without_req c%0d got gnt %b req %b", rel, bus.gnt, bus.req); end
      end
      checks++; if (n_gnt != 3) begin errors++; $display("FAIL early_burst_len got %0d expected 3", n_gnt); end
      @(negedge clk); #1;
      checks++; if (dbg_ptr !== 2'd3) begin errors++; $display("FAIL early_ptr got %0d expected 3", dbg_ptr); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL early_idle got %b expected 0", bus.busy); end
   endtask

   // Runs straight after test_early_release, with ptr at 3.
   task automatic test_wait_abort();
      @(negedge clk); bus.req = 4'b1000; #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_c0 got %b expected 0", bus.busy); end
      @(negedge clk); bus.req = 4'b0000; #1;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_c1 got %b expected 1", bus.busy); end
      checks++; if (bus.gnt_id !== 2'd3) begin errors++; $display("FAIL abort_id_c1 got %0d expected 3", bus.gnt_id); end
      for (int rel = 2; rel < 5; rel++) begin
         @(negedge clk); #1;
         checks++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin errors++; $display("FAIL abort_idle c%0d got busy %b gnt %b expected 0 0000", rel, bus.busy, bus.gnt); end
      end
      checks++; if (dbg_ptr !== 2'd3) begin errors++; $display("FAIL abort_ptr got %0d expected 3", dbg_ptr); end
      // Search must still start at 3, so 3 beats 0.
      bus.req = 4'b1001;
      @(negedge clk); #1;
      checks++; if (bus.gnt_id !== 2'd3) begin errors++; $display("FAIL abort_next_id got %0d expected 3", bus.gnt_id); end
      @(negedge clk); #1;
      checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL abort_next_gnt got %b expected 1000", bus.gnt); end
      settle();
   endtask

   task automatic test_weight_zero_change();
      logic [5:0] exp_z;
      logic [5:0] exp_c;
      exp_z = 6'b100100;   // weight 0 behaves as 1
      exp_c = 6'b001100;   // weight 2 loaded, later change to 7 ignored
      bus.cfg_weight = 16'h0000;
      do_reset();
      for (int rel = 0; rel < 6; rel++) begin
         if (rel != 0) @(negedge clk);
         bus.req = 4'b0010;
         #1;
         checks++; if (bus.gnt[1] !== exp_z[rel]) begin errors++; $display("FAIL weight0 c%0d got %b expected %b", rel, bus.gnt[1], exp_z[rel]); end
      end
      bus.cfg_weight = 16'h0020;
      do_reset();
      for (int rel = 0; rel < 6; rel++) begin
         if (rel != 0) @(negedge clk);
         bus.req = 4'b0010;
         if (rel == 2) bus.cfg_weight = 16'h0070;
         #1;
         checks++; if (bus.gnt[1] !== exp_c[rel]) begin errors++; $display("FAIL weight_change c%0d got %b expected %b", rel, bus.gnt[1], exp_c[rel]); end
         checks++; if (!$onehot0(bus.gnt) || $isunknown(bus.gnt)) begin errors++; $display("FAIL weight_onehot c%0d got %b expected one-hot or zero", rel, bus.gnt); end
      end
      settle();
   endtask

   task automatic test_reset_mid_burst();
      bus.cfg_weight = 16'h0040;
      do_reset();
      bus.req = 4'b0010;
      @(negedge clk); @(negedge clk); #1;
      checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL midrst_first got %b expected 0010", bus.gnt); end
      @(negedge clk); #1;
      checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL midrst_second got %b expected 0010", bus.gnt); end
      reset = 1'b1;
      @(negedge clk); reset = 1'b0; #1;
      checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_abort got gnt %b busy %b expected 0000 0", bus.gnt, bus.busy); end
      @(negedge clk); #1;
      checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_wait got gnt %b busy %b expected 0000 1", bus.gnt, bus.busy); end
      @(negedge clk); #1;
      checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL midrst_regrant got %b expected 0010", bus.gnt); end
      settle();
   endtask

   task automatic test_random();
      logic [N-1:0]    r;
      logic [N*WW-1:0] c;
      logic [OW-1:0]   e;
      logic [OW-1:0]   o;
      bus.cfg_weight = 16'h2341;
      do_reset();
      for (int n = 0; n < 800; n++) begin
         if (n != 0) @(negedge clk);
         r = bus.req;
         for (int i = 0; i < N; i++) begin
            if (r[i]) begin
               if ($urandom_range(0, 7) == 0) r[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               r[i] = 1'b1;
            end
         end
         bus.req = r;
         if ($urandom_range(0, 19) == 0) begin
            c = bus.cfg_weight;
            for (int i = 0; i < N; i++) c[i*WW +: WW] = WW'($urandom_range(0, 15));
            bus.cfg_weight = c;
         end
         reset = ($urandom_range(0, 149) == 0);
         #1;
         exp_q.push_back(model_out(bus.req));
         o = {bus.busy, bus.gnt_id, bus.gnt};
         e = exp_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL random c%0d got busy/id/gnt %b expected %b", n, o, e); end
         checks++; if (bus.gnt_valid !== (e[N-1:0] != '0)) begin errors++; $display("FAIL random_valid c%0d got %b expected %b", n, bus.gnt_valid, (e[N-1:0] != '0)); end
         checks++; if ((bus.gnt & ~bus.req) !== '0) begin errors++; $display("FAIL random_gnt_without_req c%0d got gnt %b req %b", n, bus.gnt, bus.req); end
      end
      reset = 1'b0;
      settle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      bus.req = '0;
      bus.cfg_weight = '0;
      test_reset();
      test_single_request();
      test_rotation();
      test_early_release();
      test_wait_abort();
      test_weight_zero_change();
      test_reset_mid_burst();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
